// File: rtl/mole_pkg.sv
// Shared types and defaults for the whack-a-mole hole selector.
package mole_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    localparam int DEF_LFSR_W    = 16;
    localparam int DEF_OUT_W     = 3;
    localparam int DEF_NUM_HOLES = 6;

    // Feedback masks per register width; bit i set means lfsr[i] feeds the XNOR.
    function automatic logic [31:0] default_taps(input int w);
        logic [31:0] taps;
        case (w)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            24:      taps = 32'h00E1_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h3 << (w - 2);
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/mole_rand_gen_lfsr_core.sv
// Free-running XNOR Fibonacci LFSR with seed load; exposes the low bits as the draw candidate.
module lfsr_core #(
    parameter int             W     = 16,
    parameter logic [W-1:0]   TAPS  = W'(16'hB400),
    parameter int             OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [W-1:0]     seed_in,
    output logic [OUT_W-1:0] cand
);

    logic [W-1:0] lfsr;
    logic         fb;

    assign fb   = ~^(lfsr & TAPS);
    assign cand = lfsr[OUT_W-1:0];

    // All-ones is the XNOR lockup state, so such a seed is replaced by zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= '0;
        end else if (seed_load) begin
            lfsr <= (&seed_in) ? '0 : seed_in;
        end else begin
            lfsr <= {lfsr[W-2:0], fb};
        end
    end

endmodule

// File: rtl/mole_rand_gen.sv
// Hole index generator: rejection-samples LFSR candidates into 0..NUM_HOLES-1,
// optionally refusing to repeat the previous index.
//   state | meaning
//   IDLE  | waiting for req; rand_out holds the last issued index
//   DRAW  | evaluating one candidate per cycle until accept or fallback
module mole_rand_gen
    import mole_pkg::*;
#(
    parameter int                LFSR_W    = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(default_taps(LFSR_W)),
    parameter int                OUT_W     = DEF_OUT_W,
    parameter int                NUM_HOLES = DEF_NUM_HOLES,
    parameter bit                NO_REPEAT = 1'b1,
    parameter int                MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req,
    output logic              rand_valid,
    output logic [OUT_W-1:0]  rand_out,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]   HOLES    = (OUT_W + 1)'(NUM_HOLES);
    localparam logic [OUT_W-1:0] TOP_HOLE = OUT_W'(NUM_HOLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] try_cnt, try_next;
    logic [OUT_W-1:0] out_next;
    logic             valid_next;
    logic             have_last, have_next;
    logic [OUT_W-1:0] cand;
    logic             reject;
    logic [OUT_W-1:0] fallback;

    lfsr_core #(
        .W     (LFSR_W),
        .TAPS  (TAPS),
        .OUT_W (OUT_W)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .cand      (cand)
    );

    assign reject = ({1'b0, cand} >= HOLES) ||
                    (NO_REPEAT && have_last && (cand == rand_out));

    // Stepping to the next hole keeps the no-repeat guarantee when sampling gives up.
    assign fallback = !have_last            ? '0 :
                      (rand_out == TOP_HOLE) ? '0 : rand_out + OUT_W'(1);

    assign busy = (state == DRAW);

    always_comb begin
        state_next = state;
        try_next   = try_cnt;
        out_next   = rand_out;
        valid_next = 1'b0;
        have_next  = have_last;
        case (state)
            IDLE: begin
                if (req && !seed_load) begin
                    state_next = DRAW;
                    try_next   = '0;
                end
            end
            DRAW: begin
                if (!reject) begin
                    out_next   = cand;
                    valid_next = 1'b1;
                    have_next  = 1'b1;
                    state_next = IDLE;
                end else if (try_cnt == LAST_TRY) begin
                    out_next   = fallback;
                    valid_next = 1'b1;
                    have_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    try_next = try_cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            try_cnt    <= '0;
            rand_out   <= '0;
            rand_valid <= 1'b0;
            have_last  <= 1'b0;
        end else begin
            state      <= state_next;
            try_cnt    <= try_next;
            rand_out   <= out_next;
            rand_valid <= valid_next;
            have_last  <= have_next;
        end
    end

endmodule

// File: tb/tb_mole_rand_gen.sv
// Directed vector table for the 6-bit configuration, a MAX_TRIES=2 fallback
// instance, and a randomised property monitor on a NUM_HOLES=5 instance.
module tb_mole_rand_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, seed_load, req;
    logic [5:0] seed_in;
    logic       va, ba, vb, bb;
    logic [2:0] oa, ob;

    logic       rst_n_c, sl_c, req_c;
    logic [5:0] si_c;
    logic       vc, bc;
    logic [2:0] oc;

    int checks   = 0;
    int failures = 0;

    mole_rand_gen #(
        .LFSR_W(6), .TAPS(6'b110000), .OUT_W(3), .NUM_HOLES(6),
        .NO_REPEAT(1'b1), .MAX_TRIES(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .rand_valid(va), .rand_out(oa), .busy(ba)
    );

    mole_rand_gen #(
        .LFSR_W(6), .TAPS(6'b110000), .OUT_W(3), .NUM_HOLES(6),
        .NO_REPEAT(1'b1), .MAX_TRIES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .rand_valid(vb), .rand_out(ob), .busy(bb)
    );

    mole_rand_gen #(
        .LFSR_W(6), .TAPS(6'b110000), .OUT_W(3), .NUM_HOLES(5),
        .NO_REPEAT(1'b1), .MAX_TRIES(8)
    ) dut_c (
        .clk(clk), .rst_n(rst_n_c), .seed_load(sl_c), .seed_in(si_c),
        .req(req_c), .rand_valid(vc), .rand_out(oc), .busy(bc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       sl;
        logic [5:0] si;
        logic       rq;
        logic       v;
        logic [2:0] o;
        logic       b;
        logic [5:0] lf;
        logic       chk_b;
        logic       vb;
        logic [2:0] ob;
        logic       bb;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    // Random-phase monitor state
    logic       mon_en = 1'b0;
    logic       prev_busy, prev_valid, have_prev;
    logic [2:0] last_out;
    int         run;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (!rst_n_c) begin
                chk("c_reset", {29'd0, vc, bc, oc != 3'd0}, 32'd0);
                prev_busy  = 1'b0;
                prev_valid = 1'b0;
                have_prev  = 1'b0;
                last_out   = 3'd0;
                run        = 0;
            end else begin
                if (vc) begin
                    chk("c_range", {31'd0, oc < 3'd5}, 32'd1);
                    if (have_prev) chk("c_norepeat", {31'd0, oc != last_out}, 32'd1);
                    chk("c_valid_gap", {31'd0, !prev_valid}, 32'd1);
                    chk("c_valid_end", {31'd0, prev_busy && !bc}, 32'd1);
                    have_prev = 1'b1;
                    last_out  = oc;
                end else begin
                    chk("c_hold", {29'd0, oc}, {29'd0, last_out});
                end
                if (bc && !prev_busy) chk("c_busy_start", {31'd0, req_c && !sl_c}, 32'd1);
                if (!bc && prev_busy) chk("c_end_pulse", {31'd0, vc}, 32'd1);
                run = bc ? run + 1 : 0;
                if (bc) chk("c_busy_len", {31'd0, run <= 8}, 32'd1);
                prev_busy  = bc;
                prev_valid = vc;
            end
        end
    end

    initial begin
        //          sl  si     rq  v  o  b  lfsr   chkb vb ob bb
        vecs[0]  = '{1, 6'h00, 0,  0, 0, 0, 6'h00, 1,   0, 0, 0};
        vecs[1]  = '{0, 6'h00, 1,  0, 0, 1, 6'h01, 1,   0, 0, 1};
        vecs[2]  = '{0, 6'h00, 0,  1, 1, 0, 6'h03, 1,   1, 1, 0};
        vecs[3]  = '{0, 6'h00, 1,  0, 1, 1, 6'h07, 1,   0, 1, 1};
        vecs[4]  = '{0, 6'h00, 1,  0, 1, 1, 6'h0F, 1,   0, 1, 1};
        vecs[5]  = '{0, 6'h00, 0,  0, 1, 1, 6'h1F, 1,   1, 2, 0};
        vecs[6]  = '{0, 6'h00, 0,  0, 1, 1, 6'h3E, 1,   0, 2, 0};
        vecs[7]  = '{0, 6'h00, 0,  0, 1, 1, 6'h3D, 1,   0, 2, 0};
        vecs[8]  = '{0, 6'h00, 0,  1, 5, 0, 6'h3B, 0,   0, 0, 0};
        vecs[9]  = '{0, 6'h00, 0,  0, 5, 0, 6'h37, 0,   0, 0, 0};
        vecs[10] = '{1, 6'h3F, 1,  0, 5, 0, 6'h00, 0,   0, 0, 0};
        vecs[11] = '{0, 6'h00, 0,  0, 5, 0, 6'h01, 0,   0, 0, 0};
        vecs[12] = '{0, 6'h00, 1,  0, 5, 1, 6'h03, 0,   0, 0, 0};
        vecs[13] = '{0, 6'h00, 0,  1, 3, 0, 6'h07, 0,   0, 0, 0};
        vecs[14] = '{1, 6'h01, 0,  0, 3, 0, 6'h01, 0,   0, 0, 0};
        vecs[15] = '{0, 6'h00, 1,  0, 3, 1, 6'h03, 0,   0, 0, 0};
        vecs[16] = '{0, 6'h00, 0,  0, 3, 1, 6'h07, 0,   0, 0, 0};
        vecs[17] = '{0, 6'h00, 0,  0, 3, 1, 6'h0F, 0,   0, 0, 0};
        vecs[18] = '{0, 6'h00, 0,  0, 3, 1, 6'h1F, 0,   0, 0, 0};
        vecs[19] = '{0, 6'h00, 0,  0, 3, 1, 6'h3E, 0,   0, 0, 0};
        vecs[20] = '{0, 6'h00, 0,  0, 3, 1, 6'h3D, 0,   0, 0, 0};
        vecs[21] = '{0, 6'h00, 0,  1, 5, 0, 6'h3B, 0,   0, 0, 0};
        vecs[22] = '{0, 6'h00, 1,  0, 5, 1, 6'h37, 0,   0, 0, 0};
        vecs[23] = '{1, 6'h02, 0,  0, 5, 1, 6'h02, 0,   0, 0, 0};
        vecs[24] = '{0, 6'h00, 0,  1, 2, 0, 6'h05, 0,   0, 0, 0};

        rst_n = 1'b0; seed_load = 1'b0; seed_in = 6'd0; req = 1'b0;
        rst_n_c = 1'b0; sl_c = 1'b0; si_c = 6'd0; req_c = 1'b0;

        #12;
        chk("reset_a", {28'd0, va, ba, oa != 3'd0, dut_a.u_lfsr.lfsr != 6'd0}, 32'd0);
        chk("reset_b", {29'd0, vb, bb, ob != 3'd0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            seed_load = vecs[i].sl;
            seed_in   = vecs[i].si;
            req       = vecs[i].rq;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), {31'd0, va}, {31'd0, vecs[i].v});
            chk($sformatf("row%0d_out", i),   {29'd0, oa}, {29'd0, vecs[i].o});
            chk($sformatf("row%0d_busy", i),  {31'd0, ba}, {31'd0, vecs[i].b});
            chk($sformatf("row%0d_lfsr", i),  {26'd0, dut_a.u_lfsr.lfsr}, {26'd0, vecs[i].lf});
            if (vecs[i].chk_b) begin
                chk($sformatf("row%0d_b_valid", i), {31'd0, vb}, {31'd0, vecs[i].vb});
                chk($sformatf("row%0d_b_out", i),   {29'd0, ob}, {29'd0, vecs[i].ob});
                chk($sformatf("row%0d_b_busy", i),  {31'd0, bb}, {31'd0, vecs[i].bb});
            end
        end

        // Reset in the middle of a draw
        seed_load = 1'b0;
        req = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_busy_before", {31'd0, ba}, 32'd1);
        req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out",   {29'd0, oa}, 32'd0);
        chk("midreset_valid", {31'd0, va}, 32'd0);
        chk("midreset_busy",  {31'd0, ba}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset_lfsr_release", {26'd0, dut_a.u_lfsr.lfsr}, 32'd0);
        @(posedge clk);
        #1;
        chk("midreset_no_pulse", {30'd0, va, ba}, 32'd0);
        chk("midreset_lfsr_step", {26'd0, dut_a.u_lfsr.lfsr}, 32'h01);

        // Randomised traffic with properties checked by the monitor
        @(negedge clk);
        prev_busy = 1'b0; prev_valid = 1'b0; have_prev = 1'b0; last_out = 3'd0; run = 0;
        rst_n_c = 1'b1;
        mon_en  = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                req_c = ($urandom_range(0, 3) != 0);
                sl_c  = ($urandom_range(0, 9) == 0);
                si_c  = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom);
            end
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clk);
                rst_n_c = 1'b0;
                @(negedge clk);
                rst_n_c = 1'b1;
            end
        end
        @(negedge clk);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mole_rand_gen.md
Name: mole_rand_gen

Overview:
Parametrised pseudo-random hole selector for the whack-a-mole game. It contains a free-running XNOR Fibonacci LFSR of configurable width and taps, with a seed-load port. On request it draws a hole index in the range 0..NUM_HOLES-1 by rejection sampling, and can optionally refuse to repeat the previous index. It sits between the game-control FSM (which issues req) and the mole display/scoring logic (which consumes rand_out on rand_valid).

Parameters:
LFSR_W, 16, LFSR register width (3..32).
TAPS, 16'hB400, feedback tap mask, LFSR_W bits; bit i set means lfsr[i] participates.
OUT_W, 3, width of rand_out; must satisfy NUM_HOLES <= 2**OUT_W and OUT_W <= LFSR_W.
NUM_HOLES, 6, number of legal hole indices (>=2 when NO_REPEAT=1).
NO_REPEAT, 1, 1 = reject a candidate equal to the previously issued index.
MAX_TRIES, 8, rejected evaluations allowed per draw before fallback (>=1).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
seed_load  in  1  load seed_in into LFSR this cycle
seed_in  in  LFSR_W  seed value
req  in  1  draw request, sampled in IDLE only
rand_valid  out  1  one-cycle pulse: rand_out updated this cycle
rand_out  out  OUT_W  last issued hole index, held between draws
busy  out  1  high while FSM is in DRAW

Behaviour:
- Reset (async, rst_n low): lfsr=0, state=IDLE, rand_out=0, rand_valid=0, busy=0, have_last=0, try_cnt=0.
- LFSR shifts every cycle regardless of state: fb = XNOR-reduce(lfsr & TAPS); lfsr <= {lfsr[LFSR_W-2:0], fb}. The all-zero state is legal; the all-ones state is the lockup state.
- seed_load has priority over the shift: lfsr <= seed_in, except all-ones seed_in, which loads all-zero. seed_load does not disturb the FSM; an active draw continues on the new LFSR value.
- Candidate = lfsr[OUT_W-1:0], using the current register value in each DRAW cycle.
- FSM IDLE:
  - req=1 and seed_load=0 -> DRAW, try_cnt=0.
  - req together with seed_load is ignored.
  - busy=0.
- FSM DRAW: each cycle evaluate the candidate.
  - Reject if candidate >= NUM_HOLES, or if NO_REPEAT=1 and have_last=1 and candidate == rand_out.
  - Accept: rand_out <= candidate, rand_valid pulses next cycle, have_last <= 1, -> IDLE.
  - Reject with try_cnt == MAX_TRIES-1: fallback rand_out <= (rand_out+1) mod NUM_HOLES (or 0 if have_last=0), pulse rand_valid, have_last <= 1, -> IDLE.
  - Otherwise try_cnt++ and stay in DRAW.
- Latency: the req sampling edge is followed by at least 1 and at most MAX_TRIES DRAW cycles; rand_valid is high in the cycle after the deciding edge.
- Back-to-back operation: rand_valid is high while the state is already IDLE, so a req in that cycle is accepted. Maximum throughput is one draw per 2 cycles.
- req while busy is ignored (no queuing).
- Reset mid-draw: immediate return to reset values, no rand_valid.
- try_cnt width: clog2(MAX_TRIES)+1; no wrap.

Decomposition:
- Shared package mole_pkg: state enum (IDLE, DRAW), default NUM_HOLES, OUT_W, and default TAPS constants per supported LFSR_W.
- One natural sub-module, lfsr_core: parametrised XNOR LFSR with shift, seed load and lockup guard. mole_rand_gen instantiates it and adds the draw FSM.

Test Plan:
All scenarios use LFSR_W=6, TAPS=6'b110000, OUT_W=3, NUM_HOLES=6 unless noted. Expected LFSR sequence from 0 is 000001, 000011, 000111, 001111, 011111, 111110, 111101.
1. Reset mid-draw: assert rst_n low while busy -> rand_out=0, rand_valid=0, busy=0 immediately; lfsr=0 on release.
2. Seed 0 at edge e0, req sampled at e1 -> DRAW sees lfsr=000001, accept at e2 -> rand_out=1, rand_valid high for exactly one cycle after e2.
3. Continue with req in the rand_valid cycle (sampled at e3) -> candidates 7, 7, 7, 6 rejected, 5 accepted at e8 -> rand_out=5, busy high for 5 cycles.
4. Same as 3 with MAX_TRIES=2 -> two rejects (7, 7), fallback at e5 -> rand_out=(1+1) mod 6 = 2, rand_valid pulse.
5. seed_load with seed_in=6'b111111 -> lfsr reads 000000 next cycle. Then 1000 random req/seed_load/reset sequences with NUM_HOLES=5, NO_REPEAT=1 -> every rand_out < 5, no two consecutive equal outputs, rand_valid never two cycles in a row, req during busy never produces an extra pulse.
